// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - parity codes, receiver state encoding and width helper
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

    // Elaboration-time ceil(log2(value)); only ever called with constants.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive queue with occupancy count
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = clog2(DEPTH);
    localparam int DEPTH_I = DEPTH;
    localparam logic [AW:0] FULL_COUNT = DEPTH_I[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampled serial receiver with majority vote, error flags and fifo
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = PAR_NONE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 clken,
    input  logic                 rx,
    input  logic                 rd_en,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 rdy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = clog2(OVERSAMPLE);
    localparam int BW = clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LO   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] CNT_HI   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY == PAR_ODD);

    rx_state_t            state;
    rx_state_t            state_next;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bitpos;
    logic [DATA_BITS-1:0] scratch;
    logic                 vote_lo;
    logic                 vote_mid;
    logic                 majority;
    logic                 par_bad;
    logic                 mid;
    logic                 wrap;
    logic                 push;
    logic                 set_pe;
    logic                 set_fe;
    logic                 set_ov;
    logic                 fifo_full;
    logic                 fifo_empty;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // The third vote is the live sample, so the decision lands on CNT_HI.
    assign mid      = clken && (cnt == CNT_HI);
    assign wrap     = clken && (cnt == CNT_LAST);
    assign majority = (vote_lo & vote_mid) | (vote_lo & rx_s) | (vote_mid & rx_s);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        push       = 1'b0;
        set_pe     = 1'b0;
        set_fe     = 1'b0;
        set_ov     = 1'b0;
        if (clken) begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) state_next = ST_START;
                end
                ST_START: begin
                    if (mid && majority) state_next = ST_IDLE;
                    else if (wrap)       state_next = ST_DATA;
                end
                ST_DATA: begin
                    if (wrap && bitpos == LAST_BIT) begin
                        state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (wrap) state_next = ST_STOP;
                end
                ST_STOP: begin
                    if (mid) begin
                        if (!majority) begin
                            set_fe     = 1'b1;
                            state_next = ST_WAIT_HIGH;
                        end else if (par_bad) begin
                            set_pe     = 1'b1;
                            state_next = ST_IDLE;
                        end else if (fifo_full && !rd_en) begin
                            set_ov     = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            push       = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bitpos   <= '0;
            scratch  <= '0;
            vote_lo  <= 1'b1;
            vote_mid <= 1'b1;
            par_bad  <= 1'b0;
        end else if (clken) begin
            if (state == ST_IDLE || state_next == ST_IDLE || state_next == ST_WAIT_HIGH) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (cnt == CNT_LO)  vote_lo  <= rx_s;
            if (cnt == CNT_MID) vote_mid <= rx_s;
            if (state != ST_DATA) begin
                bitpos <= '0;
            end else if (wrap) begin
                bitpos <= bitpos + 1'b1;
            end
            if (state == ST_DATA && mid) begin
                scratch[bitpos] <= majority;
            end
            if (state == ST_START) begin
                par_bad <= 1'b0;
            end else if (state == ST_PARITY && mid) begin
                par_bad <= ((^scratch) ^ majority) != ODD;
            end
        end
    end

    // Set wins over a simultaneous clear.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= set_pe | (parity_err & ~err_clr);
            frame_err  <= set_fe | (frame_err & ~err_clr);
            overrun    <= set_ov | (overrun & ~err_clr);
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (scratch),
        .pop       (rd_en),
        .head      (data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign rdy = !fifo_empty;

endmodule
